// File: rtl/ping_pong_rd_ctrl_pkg.sv
// Shared types and helpers for the ping-pong read controller.
package ping_pong_rd_ctrl_pkg;

  // Bits needed to address n entries (at least 1).
  function automatic int bw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Read-side sequencing: idle, issuing addresses, draining the pipeline.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DRAIN
  } rd_state_t;

endpackage

// File: rtl/ping_pong_rd_ctrl_if.sv
// Valid/ready output stream carrying one bank's contents to the consumer.
interface ping_pong_rd_ctrl_if #(
  parameter int WIDTH = 512
) ();
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/ping_pong_rd_ctrl_fifo.sv
// Small synchronous FIFO that absorbs RAM read data while the consumer stalls.
module pp_rd_fifo #(
  parameter int  W     = 513,
  parameter int  DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every register sees pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; empty pointers guarantee stale words are never presented.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ping_pong_rd_ctrl.sv
// Read/control side of ping_pong_ram: bank status, switch pulse, address issue,
// read-latency tracking and credit-limited streaming to the consumer.
module ping_pong_rd_ctrl
  import ping_pong_rd_ctrl_pkg::*;
#(
  parameter int  DEPTH  = 256,
  parameter int  WIDTH  = 512,
  parameter int  RD_LAT = 2,
  localparam int ADDR_W = bw(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_done,
  input  logic [ADDR_W:0]    wr_len,
  output logic               wr_ready,
  output logic               err,
  output logic               switch,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [WIDTH-1:0]   rd_data,
  ping_pong_rd_ctrl_if.master m_if
);

  localparam int CREDITS = RD_LAT + 2;
  localparam int CNT_W   = $clog2(CREDITS + 1);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

  logic              w_full;
  logic [ADDR_W:0]   len_w;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W-1:0] addr_hold;
  rd_state_t         state;
  rd_state_t         state_nxt;
  logic              r_busy;
  logic              wr_accept;
  logic              credit_ok;
  logic              issue;
  logic              issue_last;
  logic              beat_acc;
  logic [RD_LAT-1:0] vld_sr;
  logic [RD_LAT-1:0] last_sr;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic [WIDTH:0]    fifo_dout;

  assign r_busy    = (state != RD_IDLE);
  assign wr_ready  = ~w_full;
  assign switch    = w_full & ~r_busy;
  assign wr_accept = wr_done & ~w_full & (wr_len != '0);

  // Reads in flight between rd_addr and the FIFO input.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_sr[i]);
  end

  // Only issue when the FIFO is guaranteed room for every read already in flight.
  assign credit_ok  = (int'(inflight) + int'(fifo_cnt)) < CREDITS;
  assign issue      = (state == RD_ISSUE) && credit_ok;
  assign issue_last = issue && (issue_cnt == len_r - LEN_ONE);
  assign rd_addr    = issue ? issue_cnt[ADDR_W-1:0] : addr_hold;

  assign m_if.m_valid = ~fifo_empty;
  assign m_if.m_data  = fifo_dout[WIDTH-1:0];
  assign m_if.m_last  = fifo_dout[WIDTH] & ~fifo_empty;
  assign beat_acc     = m_if.m_valid & m_if.m_ready;

  // Write-bank status: accept a filled bank, flag protocol violations, release on switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_full <= 1'b0;
      len_w  <= '0;
      err    <= 1'b0;
    end else begin
      err <= wr_done & ~wr_accept;
      if (wr_accept) begin
        w_full <= 1'b1;
        len_w  <= wr_len;
      end else if (switch) begin
        w_full <= 1'b0;
      end
    end
  end

  // Reader state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RD_IDLE;
    else        state <= state_nxt;
  end

  // Reader next state: issue len_r addresses, then wait for the tagged last beat to leave.
  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE:  if (switch) state_nxt = RD_ISSUE;
      RD_ISSUE: if (issue_last) state_nxt = RD_DRAIN;
      RD_DRAIN: if (beat_acc && m_if.m_last) state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  // Read-bank length and address counter; rd_addr holds its last value between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r     <= '0;
      issue_cnt <= '0;
      addr_hold <= '0;
    end else if (switch) begin
      len_r     <= len_w;
      issue_cnt <= '0;
    end else if (issue) begin
      issue_cnt <= issue_cnt + LEN_ONE;
      addr_hold <= issue_cnt[ADDR_W-1:0];
    end
  end

  // Latency shift register: marks when rd_data belongs to an issued address, plus its last tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= issue;
      last_sr[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  pp_rd_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (CREDITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_sr[RD_LAT-1]),
    .din   ({last_sr[RD_LAT-1], rd_data}),
    .pop   (beat_acc),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_ping_pong_rd_ctrl.sv
// Bench for ping_pong_rd_ctrl with a behavioural ping_pong_ram and producer model.
module tb_ping_pong_rd_ctrl;
  import ping_pong_rd_ctrl_pkg::*;

  localparam int DEPTH   = 256;
  localparam int WIDTH   = 512;
  localparam int RD_LAT  = 2;
  localparam int ADDR_W  = bw(DEPTH);
  localparam int CREDITS = RD_LAT + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_done;
  logic [ADDR_W:0]   wr_len;
  logic              wr_ready;
  logic              err;
  logic              switch;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              m_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ping_pong_rd_ctrl_if #(.WIDTH(WIDTH)) m_if ();
  assign m_if.m_ready = m_ready;

  ping_pong_rd_ctrl #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_done  (wr_done),
    .wr_len   (wr_len),
    .wr_ready (wr_ready),
    .err      (err),
    .switch   (switch),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .m_if     (m_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ping_pong_ram model: bank flag toggles on switch and is never reset.
  logic [WIDTH-1:0] bank0 [DEPTH];
  logic [WIDTH-1:0] bank1 [DEPTH];
  logic [WIDTH-1:0] pipe  [RD_LAT];
  logic             rd_bank = 1'b1;

  always @(posedge clk) begin
    if (switch) rd_bank <= ~rd_bank;
    pipe[0] <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rd_data = pipe[RD_LAT-1];

  function automatic logic [WIDTH-1:0] pat(input int v);
    return {(WIDTH / 32){v[31:0]}};
  endfunction

  // Producer model: write into the write bank, or into the read bank when other=1.
  task automatic fill(input int base, input int len, input bit other);
    for (int i = 0; i < len; i++) begin
      if (rd_bank ^ other) bank0[i] = pat(base + i);
      else                 bank1[i] = pat(base + i);
    end
  endtask

  // Scoreboard capture of accepted beats and switch pulses.
  logic [WIDTH-1:0] got_d [$];
  logic             got_l [$];
  int               got_c [$];
  int               sw_c  [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.m_valid && m_ready) begin
        got_d.push_back(m_if.m_data);
        got_l.push_back(m_if.m_last);
        got_c.push_back(cyc);
      end
      if (switch) sw_c.push_back(cyc);
    end
  end

  // Credit invariant: the FIFO can never be asked to hold more than its depth.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (int'(dut.inflight) + int'(dut.fifo_cnt) <= CREDITS)
      else begin
        errors++;
        $display("FAIL fifo_credit: inflight+count=%0d limit=%0d",
                 int'(dut.inflight) + int'(dut.fifo_cnt), CREDITS);
      end
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_d.delete();
    got_l.delete();
    got_c.delete();
    sw_c.delete();
  endtask

  task automatic pulse_wr(input int len);
    wr_done = 1'b1;
    wr_len  = (ADDR_W + 1)'(len);
    step();
    wr_done = 1'b0;
    wr_len  = '0;
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int k = 0;
    while (got_d.size() < n && k < budget) begin
      step();
      k++;
    end
    check({name, "_beat_count"}, got_d.size(), n);
  endtask

  task automatic check_stream(input string name, input int start, input int base, input int len);
    int bad_d = 0;
    int bad_l = 0;
    for (int i = 0; i < len; i++) begin
      if (start + i >= got_d.size()) begin
        bad_d++;
        bad_l++;
      end else begin
        if (got_d[start+i] !== pat(base + i)) bad_d++;
        if (got_l[start+i] !== (i == len - 1)) bad_l++;
      end
    end
    check({name, "_data_errs"}, bad_d, 0);
    check({name, "_last_errs"}, bad_l, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wr_ready"}, wr_ready, 1'b1);
    check({name, "_switch"}, switch, 1'b0);
    check({name, "_err"}, err, 1'b0);
    check({name, "_m_valid"}, m_if.m_valid, 1'b0);
    check({name, "_m_last"}, m_if.m_last, 1'b0);
    check({name, "_rd_addr"}, rd_addr, '0);
  endtask

  // Per-cycle vectors: len-2 transfer with violations, backpressure, back-to-back switch, len-1 transfer.
  typedef struct {
    logic wd;
    int   len;
    logic rdy;
    logic e_wr_ready;
    logic e_sw;
    logic e_err;
    logic e_valid;
    logic e_last;
    int   e_val;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 500};
    tbl[6]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 500};
    tbl[7]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 501};
    tbl[8]  = '{1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[11] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[12] = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 600};
    tbl[13] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 600};
    tbl[14] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    rst_n   = 1'b0;
    wr_done = 1'b0;
    wr_len  = '0;
    m_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Cycle-exact vector table.
    fill(500, 2, 1'b0);
    fill(600, 1, 1'b1);
    for (int r = 0; r < 15; r++) begin
      wr_done = tbl[r].wd;
      wr_len  = (ADDR_W + 1)'(tbl[r].len);
      m_ready = tbl[r].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_wr_ready", r), wr_ready, tbl[r].e_wr_ready);
      check($sformatf("vec%0d_switch", r), switch, tbl[r].e_sw);
      check($sformatf("vec%0d_err", r), err, tbl[r].e_err);
      check($sformatf("vec%0d_m_valid", r), m_if.m_valid, tbl[r].e_valid);
      check($sformatf("vec%0d_m_last", r), m_if.m_last, tbl[r].e_last);
      if (tbl[r].e_valid) check($sformatf("vec%0d_m_data", r), m_if.m_data, pat(tbl[r].e_val));
      step();
    end
    wr_done = 1'b0;
    wr_len  = '0;
    m_ready = 1'b1;
    repeat (3) step();
    clear_q();

    // Full bank A, then bank B queued behind it, plus a violation while B waits.
    fill(0, DEPTH, 1'b0);
    pulse_wr(DEPTH);
    @(negedge clk);
    check("full_switch_latency", switch, 1'b1);
    step();
    @(negedge clk);
    check("full_wr_ready_after_switch", wr_ready, 1'b1);
    step();
    fill(1000, 100, 1'b0);
    pulse_wr(100);
    wr_done = 1'b1;
    wr_len  = (ADDR_W + 1)'(50);
    @(negedge clk);
    check("busy_wr_ready_low", wr_ready, 1'b0);
    step();
    wr_done = 1'b0;
    wr_len  = '0;
    @(negedge clk);
    check("busy_err_pulse", err, 1'b1);
    step();
    @(negedge clk);
    check("busy_err_single", err, 1'b0);
    wait_beats("pingpong", DEPTH + 100, 1500);
    check_stream("bank_a", 0, 0, DEPTH);
    check_stream("bank_b", DEPTH, 1000, 100);
    if (got_c.size() > DEPTH - 1) begin
      check("bank_a_back_to_back", got_c[DEPTH-1] - got_c[0], DEPTH - 1);
      check("second_switch_count", sw_c.size(), 2);
      if (sw_c.size() > 1) check("second_switch_timing", sw_c[1], got_c[DEPTH-1] + 1);
    end
    repeat (3) step();
    clear_q();

    // Random backpressure over a 37-entry bank.
    fill(2000, 37, 1'b0);
    pulse_wr(37);
    for (int k = 0; k < 800 && got_d.size() < 37; k++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    check("random_beat_count", got_d.size(), 37);
    check_stream("random", 0, 2000, 37);
    repeat (3) step();
    clear_q();

    // Full bank with consumer stalled 20 cycles: issue stops at the credit limit.
    m_ready = 1'b0;
    fill(3000, DEPTH, 1'b0);
    pulse_wr(DEPTH);
    repeat (20) step();
    @(negedge clk);
    check("stall_rd_addr_hold", rd_addr, CREDITS - 1);
    check("stall_m_valid", m_if.m_valid, 1'b1);
    check("stall_m_data_head", m_if.m_data, pat(3000));
    check("stall_no_beats", got_d.size(), 0);
    step();
    m_ready = 1'b1;
    wait_beats("stall", DEPTH, 1000);
    check_stream("stall", 0, 3000, DEPTH);
    repeat (3) step();
    clear_q();

    // Reset in the middle of a stream with the other bank already full.
    fill(4000, DEPTH, 1'b0);
    pulse_wr(DEPTH);
    repeat (2) step();
    fill(5000, 10, 1'b0);
    pulse_wr(10);
    repeat (20) step();
    check("midreset_pre_wr_ready", wr_ready, 1'b0);
    check("midreset_pre_m_valid", m_if.m_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    repeat (10) step();
    check("midreset_no_beats", got_d.size(), 0);
    check("midreset_no_switch", sw_c.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
